adder_divider: RTL and testbench

ADDER_DIVIDER -- requirements
Module: seq_divider

---
 rtl/adder_divider.sv | 127 ++++++++++++
 tb/tb_adder_divider.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_divider.sv
// 4-bit unsigned sequential restoring divider: IDLE -> CALC (4 iterations) -> DONE.
// Divide-by-zero bypasses CALC and reports Quotient=4'hF, Remainder=A, DivZero=1.
module adder_divider (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       En,
  input  logic       Start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Quotient,
  output logic [3:0] Remainder,
  output logic       Busy,
  output logic       Done,
  output logic       DivZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [4:0] prem_q, prem_d;
  logic [3:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [2:0] qacc_q, qacc_d;
  logic [3:0] quo_q, quo_d;
  logic [3:0] rem_q, rem_d;
  logic       dz_q, dz_d;

  logic [4:0] trial;
  logic [5:0] diff;
  logic       qbit;
  logic [4:0] prem_next;

  always_comb begin
    // Shift the partial remainder left and bring in the next dividend bit;
    // prem_q[4] set would mean the shifted value already exceeds any divisor.
    trial     = {prem_q[3:0], dvd_q[3]};
    diff      = {1'b0, trial} - {2'b00, dvs_q};
    qbit      = prem_q[4] | ~diff[5];
    prem_next = qbit ? diff[4:0] : trial;

    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qacc_d  = qacc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    if (En) begin
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            if (B != 4'd0) begin
              dvd_d   = A;
              dvs_d   = B;
              prem_d  = '0;
              qacc_d  = '0;
              cnt_d   = '0;
              state_d = CALC;
            end else begin
              quo_d   = '1;
              rem_d   = A;
              dz_d    = 1'b1;
              state_d = DONE;
            end
          end
        end
        CALC: begin
          prem_d = prem_next;
          dvd_d  = {dvd_q[2:0], 1'b0};
          qacc_d = {qacc_q[1:0], qbit};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            quo_d   = {qacc_q, qbit};
            rem_d   = prem_next[3:0];
            dz_d    = 1'b0;
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qacc_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qacc_q  <= qacc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivZero   = dz_q;
  assign Busy      = (state_q == CALC);
  assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_adder_divider.sv
// Self-checking bench for adder_divider: directed vector table, hand-written
// multi-cycle sequences, and randomized divisions checked against plain arithmetic.
module tb_adder_divider;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       En;
  logic       Start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Quotient;
  logic [3:0] Remainder;
  logic       Busy;
  logic       Done;
  logic       DivZero;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  adder_divider dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .En       (En),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .Busy     (Busy),
    .Done     (Done),
    .DivZero  (DivZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
    int lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic model(input int a, input int b, output int q, output int r, output int dz);
    if (b == 0) begin
      q = 15; r = a; dz = 1;
    end else begin
      q = a / b; r = a % b; dz = 0;
    end
  endtask

  always @(negedge Clk) begin
    if (mon_on) begin
      total++;
      if (Busy === 1'b1 && Done === 1'b1) begin
        bad++;
        $display("FAIL busy_done_overlap: got Busy=1 Done=1 expected not both (t=%0t)", $time);
      end
    end
  end

  // One division; En is dropped for stall_len edges starting after edge stall_at
  // (counted from the accepting edge). A/B/Start are scrambled after acceptance.
  task automatic run_div(input int a, input int b, input int stall_at, input int stall_len,
                         input string tag);
    int q, r, dz, lat, busy_cnt, exp_lat;
    model(a, b, q, r, dz);
    exp_lat = (b == 0) ? 0 : 4 + stall_len;
    @(negedge Clk);
    A = 4'(a); B = 4'(b); Start = 1'b1; En = 1'b1;
    @(posedge Clk); #1;
    A = 4'($urandom_range(0, 15));
    B = 4'($urandom_range(0, 15));
    Start = 1'($urandom_range(0, 1));
    lat = 0;
    busy_cnt = 0;
    while (Done !== 1'b1 && lat < 30) begin
      if (Busy === 1'b1) busy_cnt++;
      @(negedge Clk);
      En = !(lat >= stall_at && lat < stall_at + stall_len);
      @(posedge Clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, busy_cnt, (b == 0) ? 0 : 4 + stall_len);
    chk({tag, "_quotient"}, Quotient, q);
    chk({tag, "_remainder"}, Remainder, r);
    chk({tag, "_divzero"}, DivZero, dz);
    @(negedge Clk);
    En = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk({tag, "_done_pulse_end"}, Done, 0);
    chk({tag, "_hold_quotient"}, Quotient, q);
    chk({tag, "_hold_remainder"}, Remainder, r);
    chk({tag, "_hold_divzero"}, DivZero, dz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, r, dz, lat;
    bit seen;

    vecs[0] = '{a: 7,  b: 2,  q: 3,  r: 1, dz: 0, lat: 4};
    vecs[1] = '{a: 15, b: 1,  q: 15, r: 0, dz: 0, lat: 4};
    vecs[2] = '{a: 3,  b: 4,  q: 0,  r: 3, dz: 0, lat: 4};
    vecs[3] = '{a: 9,  b: 0,  q: 15, r: 9, dz: 1, lat: 0};
    vecs[4] = '{a: 10, b: 3,  q: 3,  r: 1, dz: 0, lat: 4};
    vecs[5] = '{a: 0,  b: 5,  q: 0,  r: 0, dz: 0, lat: 4};
    vecs[6] = '{a: 14, b: 3,  q: 4,  r: 2, dz: 0, lat: 4};
    vecs[7] = '{a: 15, b: 15, q: 1,  r: 0, dz: 0, lat: 4};
    vecs[8] = '{a: 0,  b: 0,  q: 15, r: 0, dz: 1, lat: 0};
    vecs[9] = '{a: 12, b: 1,  q: 12, r: 0, dz: 0, lat: 4};

    // Reset wins over En=0 and Start=1.
    Reset = 1'b1; En = 1'b0; Start = 1'b1; A = 4'd5; B = 4'd2;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rst_quotient", Quotient, 0);
    chk("rst_remainder", Remainder, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_divzero", DivZero, 0);
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0; En = 1'b1;
    mon_on = 1'b1;

    for (int i = 0; i < 10; i++) begin
      int lat_len;
      lat_len = vecs[i].lat;
      run_div(vecs[i].a, vecs[i].b, 99, 0, $sformatf("vec%0d", i));
      model(vecs[i].a, vecs[i].b, q, r, dz);
      chk($sformatf("vec%0d_table_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_table_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_table_lat", i), (vecs[i].b == 0) ? 0 : 4, lat_len);
    end

    // Three stalled cycles in CALC delay Done by exactly three.
    run_div(13, 5, 1, 3, "stall13_5");

    // Start held high: next acceptance only after the DONE->IDLE edge.
    @(negedge Clk);
    A = 4'd8; B = 4'd3; Start = 1'b1; En = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("hold_busy_k%0d", k), Busy, (k % 6) < 4);
      chk($sformatf("hold_done_k%0d", k), Done, (k % 6) == 4);
      if ((k % 6) == 4) begin
        chk($sformatf("hold_q_k%0d", k), Quotient, 2);
        chk($sformatf("hold_r_k%0d", k), Remainder, 2);
      end
    end
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk); #1;

    // Done stays high while stalled in DONE.
    @(negedge Clk);
    A = 4'd6; B = 4'd4; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("dstall_done", Done, 1);
    chk("dstall_q", Quotient, 1);
    chk("dstall_r", Remainder, 2);
    @(negedge Clk);
    En = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("dstall_done_held%0d", k), Done, 1);
    end
    @(negedge Clk);
    En = 1'b1;
    @(posedge Clk); #1;
    chk("dstall_done_released", Done, 0);

    // Reset at E2 aborts; a Start right after deassertion is accepted.
    @(negedge Clk);
    A = 4'd14; B = 4'd3; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("abort_quotient", Quotient, 0);
    chk("abort_remainder", Remainder, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_divzero", DivZero, 0);
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b1; A = 4'd14; B = 4'd3;
    @(posedge Clk); #1;
    Start = 1'b0;
    chk("abort_restart_busy", Busy, 1);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
      if (Done === 1'b1) seen = 1'b1;
    end
    chk("abort_restart_latency", lat, 4);
    chk("abort_restart_q", Quotient, 4);
    chk("abort_restart_r", Remainder, 2);
    @(posedge Clk); #1;

    for (int n = 0; n < 40; n++) begin
      int ra, rb, sa, sl;
      ra = $urandom_range(0, 15);
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      sl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      sa = (sl != 0) ? $urandom_range(0, 3) : 99;
      run_div(ra, rb, sa, sl, $sformatf("rnd%0d_%0d_%0d", n, ra, rb));
    end

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
